// File: rtl/ram_param_sp.sv
// Parametrised single-port synchronous RAM with a clear sequencer, read-valid strobe and range-error flag.
// Latency: read data, valid and err appear 1 cycle after the access (2 cycles when OUT_REG=1).
// Backpressure: none per access; ready=0 while the clear sequencer sweeps memory, and accesses are ignored then.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   rst_n  - asynchronous reset, active low
//   en     - access enable, accepted only while ready=1
//   we     - write enable, qualified by en
//   addr   - word address (unsigned, range-checked against DEPTH, no wrap)
//   din    - write data
//   clr    - single-cycle request for a full-memory clear, sampled while ready=1
//   dout   - read data, holds between accepted accesses
//   valid  - dout was updated by an accepted access
//   ready  - 1 = accesses accepted, 0 = clear sweep in progress
//   err    - 1-cycle pulse, aligned with valid, for an access with addr >= DEPTH
//
// RD_MODE selects what a write returns on dout: 0 old word, 1 new word, 2 nothing (dout holds, valid=0).

module ram_param_sp #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter int                RD_MODE   = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              ready,
  output logic              err
);

  // Word index width; a single-word memory still needs one index bit.
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH held one bit wider than addr so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              in_range;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  logic              mem_we;
  logic [CNT_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              res_vld;
  logic              res_err;
  logic [DATA_W-1:0] res_dat;

  logic              o_vld;
  logic              o_err;
  logic [DATA_W-1:0] o_dat;

  // ---------------------------------------------------------------------------
  // Access qualification. A clr request in the same cycle wins over the access.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc      = (state_q == S_READY) && en && !clr;
    in_range = ({1'b0, addr} < DEPTH_V);
    idx      = addr[CNT_W-1:0];
    // Only meaningful when in_range; the gate keeps out-of-range reads at zero.
    rd_word  = in_range ? mem[idx] : '0;
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        if (clr) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign ready = (state_q == S_READY);

  // ---------------------------------------------------------------------------
  // Memory write port, shared between the sweep and normal writes.
  // Out-of-range writes never reach the array.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt_q;
      mem_wd = CLEAR_VAL;
    end else if (acc && we && in_range) begin
      mem_we = 1'b1;
      mem_wa = idx;
      mem_wd = din;
    end
  end

  // The array has no reset: its contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Access result. rd_word is sampled before the write lands, which gives the
  // old word for a read-first write.
  // ---------------------------------------------------------------------------
  always_comb begin
    res_vld = 1'b0;
    res_err = 1'b0;
    res_dat = '0;
    if (acc) begin
      if (!in_range) begin
        res_vld = 1'b1;
        res_err = 1'b1;
        res_dat = '0;
      end else if (!we) begin
        res_vld = 1'b1;
        res_dat = rd_word;
      end else if (RD_MODE == 1) begin
        res_vld = 1'b1;
        res_dat = din;
      end else if (RD_MODE == 2) begin
        res_vld = 1'b0;
      end else begin
        res_vld = 1'b1;
        res_dat = rd_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional extra stage. It advances every cycle, so an in-flight result
  // still reaches the outputs when en drops or a clear starts.
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_oreg
    logic              p_vld;
    logic              p_err;
    logic [DATA_W-1:0] p_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_vld <= 1'b0;
        p_err <= 1'b0;
        p_dat <= '0;
      end else begin
        p_vld <= res_vld;
        p_err <= res_err;
        p_dat <= res_dat;
      end
    end

    assign o_vld = p_vld;
    assign o_err = p_err;
    assign o_dat = p_dat;
  end else begin : g_nreg
    assign o_vld = res_vld;
    assign o_err = res_err;
    assign o_dat = res_dat;
  end

  // Output register: dout only moves on a valid result, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= o_vld;
      err   <= o_err;
      if (o_vld) begin
        dout <= o_dat;
      end
    end
  end

endmodule

// File: tb/tb_ram_param_sp.sv
// Self-checking bench for ram_param_sp: four instances with different mode/latency/depth settings
// share one stimulus stream; a per-instance reference model predicts ready, dout, valid and err.
// Outputs are compared on every falling clock edge; inputs change just after falling edges.

module tb_ram_param_sp;

  localparam int NI = 4;
  localparam int        AWS [NI] = '{4, 4, 4, 5};
  localparam int        DEPS[NI] = '{12, 12, 12, 16};
  localparam int        RMS [NI] = '{0, 1, 2, 2};
  localparam int        ORS [NI] = '{0, 1, 0, 1};
  localparam logic [7:0] CVS[NI] = '{8'h00, 8'h3C, 8'h5A, 8'hE7};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       we    = 1'b0;
  logic       clr   = 1'b0;
  logic [4:0] addr  = '0;
  logic [7:0] din   = '0;

  logic [7:0] dout_w [NI];
  logic       valid_w[NI];
  logic       ready_w[NI];
  logic       err_w  [NI];

  always #5 clk = ~clk;

  ram_param_sp #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_MODE(0), .OUT_REG(0), .CLEAR_VAL(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr[3:0]), .din(din), .clr(clr),
    .dout(dout_w[0]), .valid(valid_w[0]), .ready(ready_w[0]), .err(err_w[0]));

  ram_param_sp #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .OUT_REG(1), .CLEAR_VAL(8'h3C)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr[3:0]), .din(din), .clr(clr),
    .dout(dout_w[1]), .valid(valid_w[1]), .ready(ready_w[1]), .err(err_w[1]));

  ram_param_sp #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_MODE(2), .OUT_REG(0), .CLEAR_VAL(8'h5A)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr[3:0]), .din(din), .clr(clr),
    .dout(dout_w[2]), .valid(valid_w[2]), .ready(ready_w[2]), .err(err_w[2]));

  ram_param_sp #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_MODE(2), .OUT_REG(1), .CLEAR_VAL(8'hE7)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din), .clr(clr),
    .dout(dout_w[3]), .valid(valid_w[3]), .ready(ready_w[3]), .err(err_w[3]));

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [7:0] mmem [NI][32];
  bit         mrdy [NI];
  int         mleft[NI];   // words still to clear
  bit         pv [NI];     // result waiting in the extra stage (latency 2)
  bit         pe [NI];
  logic [7:0] pd [NI];
  logic [7:0] edout[NI];
  bit         evld [NI];
  bit         eerr [NI];

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mrdy[k]  = 1'b0;
      mleft[k] = DEPS[k];
      pv[k]    = 1'b0;
      pe[k]    = 1'b0;
      pd[k]    = 8'h00;
      edout[k] = 8'h00;
      evld[k]  = 1'b0;
      eerr[k]  = 1'b0;
    end
  endtask

  // One clock edge of behaviour, from the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int         a;
      bit         rv, re, dv, de;
      logic [7:0] rd, dd, old;
      rv = 1'b0; re = 1'b0; rd = 8'h00;
      a  = int'(addr) & ((1 << AWS[k]) - 1);
      if (!mrdy[k]) begin
        mmem[k][DEPS[k] - mleft[k]] = CVS[k];
        mleft[k]--;
        if (mleft[k] == 0) mrdy[k] = 1'b1;
      end else if (clr) begin
        mrdy[k]  = 1'b0;
        mleft[k] = DEPS[k];
      end else if (en) begin
        if (a >= DEPS[k]) begin
          rv = 1'b1; re = 1'b1; rd = 8'h00;
        end else if (!we) begin
          rv = 1'b1; rd = mmem[k][a];
        end else begin
          old = mmem[k][a];
          mmem[k][a] = din;
          case (RMS[k])
            0:       begin rv = 1'b1; rd = old; end
            1:       begin rv = 1'b1; rd = din; end
            default: rv = 1'b0;
          endcase
        end
      end
      if (ORS[k] != 0) begin
        dv = pv[k]; de = pe[k]; dd = pd[k];
        pv[k] = rv; pe[k] = re; pd[k] = rd;
      end else begin
        dv = rv; de = re; dd = rd;
      end
      evld[k] = dv;
      eerr[k] = de;
      if (dv) edout[k] = dd;
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d ready", k), 32'(ready_w[k]), 32'(mrdy[k]));
      chk($sformatf("u%0d valid", k), 32'(valid_w[k]), 32'(evld[k]));
      chk($sformatf("u%0d err", k),   32'(err_w[k]),   32'(eerr[k]));
      chk($sformatf("u%0d dout", k),  32'(dout_w[k]),  32'(edout[k]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) check_all();
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input bit w, input int a, input int d, input bit c);
    en   = e;
    we   = w;
    addr = 5'(a);
    din  = 8'(d);
    clr  = c;
    cyc();
  endtask

  task automatic rd(input int a);
    drive(1'b1, 1'b0, a, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int d);
    drive(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    model_reset();
    chk_on = 1'b1;

    // Reset held three cycles, then the power-on sweep.
    repeat (3) cyc();
    rst_n = 1'b1;
    idle(20);
    for (int a = 0; a < 32; a++) rd(a);
    idle(3);

    // Plain write/read, including an address beyond the 12-word instances.
    wr(3, 8'hA5);
    wr(15, 8'h5A);
    rd(3);
    rd(15);
    idle(3);

    // Read-during-write behaviour.
    wr(4, 8'h11);
    wr(4, 8'h22);
    rd(4);
    idle(3);

    // Out-of-range write then read; in-range words must be untouched.
    wr(13, 8'h77);
    rd(13);
    for (int a = 0; a < 12; a++) rd(a);
    idle(3);

    // Fill, then a clear request colliding with a write.
    for (int a = 0; a < 16; a++) wr(a, a);
    drive(1'b1, 1'b1, 2, 8'hFF, 1'b1);
    idle(20);
    for (int a = 0; a < 32; a++) rd(a);
    idle(3);

    // Reset in the middle of a sweep.
    for (int a = 0; a < 16; a++) wr(a, 8'hF0 | a);
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    idle(7);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) cyc();
    rst_n = 1'b1;
    idle(20);
    for (int a = 0; a < 32; a++) rd(a);
    idle(3);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 2) != 0, int'($urandom % 32),
            int'($urandom % 256), ($urandom % 80) == 0);
    end
    idle(20);
    for (int a = 0; a < 32; a++) rd(a);
    idle(4);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
